// File: rtl/timer_ctrl.sv
// Programmable timer sequencer driving one loadable 8-bit counter (load / prescaled enable / match / done).
// Optional capture port pair is built only when TIMER_CTRL_CAPTURE_EN is defined.
module timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] match_val_i,
    input  logic [PW-1:0]    presc_i,
    input  logic [WIDTH-1:0] cnt_dat_i,
`ifdef TIMER_CTRL_CAPTURE_EN
    input  logic             capture_i,
    output logic [WIDTH-1:0] cap_o,
`endif
    output logic             cnt_clr_o,
    output logic             cnt_en_o,
    output logic             cnt_we_o,
    output logic [WIDTH-1:0] cnt_dat_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        CLR  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] match_q, match_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [PW-1:0]    pc_q, pc_d;
    logic             done_q, done_d;
    logic             tick;
    logic             match;

    assign tick  = (pc_q == presc_q);
    assign match = (cnt_dat_i == match_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            load_q  <= '0;
            match_q <= '0;
            presc_q <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            load_q  <= load_d;
            match_q <= match_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        load_d    = load_q;
        match_d   = match_q;
        presc_d   = presc_q;
        pc_d      = '0;
        done_d    = 1'b0;
        cnt_clr_o = 1'b0;
        cnt_en_o  = 1'b0;
        cnt_we_o  = 1'b0;
        busy_o    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    mode_d  = mode_i;
                    load_d  = load_val_i;
                    match_d = match_val_i;
                    presc_d = presc_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_we_o = 1'b1;
                state_d  = stop_i ? CLR : RUN;
            end
            RUN: begin
                pc_d     = tick ? '0 : pc_q + 1'b1;
                // Gating with match keeps the counter parked on the terminal value.
                cnt_en_o = tick & ~match;
                done_d   = match;
                if (stop_i)
                    state_d = CLR;
                else if (match)
                    state_d = mode_q ? LOAD : IDLE;
            end
            CLR: begin
                cnt_clr_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_dat_o = load_q;
    assign done_o    = done_q;

`ifdef TIMER_CTRL_CAPTURE_EN
    logic [WIDTH-1:0] cap_q, cap_d;

    always_comb begin
        cap_d = cap_q;
        if (capture_i && busy_o)
            cap_d = cnt_dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cap_q <= '0;
        else
            cap_q <= cap_d;
    end

    assign cap_o = cap_q;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural loadable counter closing the feedback loop.
module tb_timer_ctrl;
    localparam int WIDTH = 8;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             rst_i, start_i, stop_i, mode_i;
    logic [WIDTH-1:0] load_val_i, match_val_i;
    logic [PW-1:0]    presc_i;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_clr_o, cnt_en_o, cnt_we_o, busy_o, done_o;
    logic [WIDTH-1:0] cnt_dat_o;
`ifdef TIMER_CTRL_CAPTURE_EN
    logic             capture_i;
    logic [WIDTH-1:0] cap_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .mode_i     (mode_i),
        .load_val_i (load_val_i),
        .match_val_i(match_val_i),
        .presc_i    (presc_i),
        .cnt_dat_i  (cnt_q),
`ifdef TIMER_CTRL_CAPTURE_EN
        .capture_i  (capture_i),
        .cap_o      (cap_o),
`endif
        .cnt_clr_o  (cnt_clr_o),
        .cnt_en_o   (cnt_en_o),
        .cnt_we_o   (cnt_we_o),
        .cnt_dat_o  (cnt_dat_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // Loadable counter: clr over we over en.
    always_ff @(posedge clk) begin
        if (rst_i)          cnt_q <= '0;
        else if (cnt_clr_o) cnt_q <= '0;
        else if (cnt_we_o)  cnt_q <= cnt_dat_o;
        else if (cnt_en_o)  cnt_q <= cnt_q + 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic arm(input logic m, input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] mt,
                       input logic [PW-1:0] ps);
        mode_i      = m;
        load_val_i  = ld;
        match_val_i = mt;
        presc_i     = ps;
        start_i     = 1'b1;
        step();
        start_i     = 1'b0;
    endtask

    initial begin
        int done_t[$];
        int t;
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
        load_val_i = '0; match_val_i = '0; presc_i = '0;
`ifdef TIMER_CTRL_CAPTURE_EN
        capture_i = 1'b0;
`endif
        step();
        step();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_clr",  32'(cnt_clr_o), 0);
        chk("rst_en",   32'(cnt_en_o), 0);
        chk("rst_we",   32'(cnt_we_o), 0);
        chk("rst_dat",  32'(cnt_dat_o), 0);
        rst_i = 1'b0;
        step();

        // One-shot, presc 0: A5 -> A8.
        arm(1'b0, 8'hA5, 8'hA8, 4'd0);
        chk("os_load_we",  32'(cnt_we_o), 1);
        chk("os_load_dat", 32'(cnt_dat_o), 32'hA5);
        chk("os_load_busy", 32'(busy_o), 1);
        load_val_i = 8'h33; match_val_i = 8'h44;  // ignored while busy
        step();
        chk("os_c2_en",  32'(cnt_en_o), 1);
        chk("os_c2_cnt", 32'(cnt_q), 32'hA5);
        step();
        chk("os_c3_en",  32'(cnt_en_o), 1);
        step();
        chk("os_c4_en",  32'(cnt_en_o), 1);
        chk("os_c4_cnt", 32'(cnt_q), 32'hA7);
        step();
        chk("os_c5_cnt",  32'(cnt_q), 32'hA8);
        chk("os_c5_en",   32'(cnt_en_o), 0);
        chk("os_c5_done", 32'(done_o), 0);
        step();
        chk("os_c6_done", 32'(done_o), 1);
        chk("os_c6_busy", 32'(busy_o), 0);
        chk("os_c6_cnt",  32'(cnt_q), 32'hA8);
        step();
        chk("os_c7_done", 32'(done_o), 0);
        chk("os_c7_cnt",  32'(cnt_q), 32'hA8);

        // Prescale 3: enable every 4th RUN cycle, done 9 cycles after first RUN.
        arm(1'b0, 8'h00, 8'h02, 4'd3);
        for (int k = 0; k <= 8; k++) begin
            step();
            chk($sformatf("ps_en_r%0d", k), 32'(cnt_en_o), 32'((k == 3) || (k == 7)));
            chk($sformatf("ps_done_r%0d", k), 32'(done_o), 0);
        end
        step();
        chk("ps_done_r9", 32'(done_o), 1);
        chk("ps_cnt_r9",  32'(cnt_q), 32'h02);

        // Periodic wrap FE..01, reload each time.
        step();
        arm(1'b1, 8'hFE, 8'h01, 4'd0);
        step(); chk("per_cnt0", 32'(cnt_q), 32'hFE);
        step(); chk("per_cnt1", 32'(cnt_q), 32'hFF);
        step(); chk("per_cnt2", 32'(cnt_q), 32'h00);
        step(); chk("per_cnt3", 32'(cnt_q), 32'h01);
        t = 0;
        while (done_t.size() < 3 && t < 40) begin
            step();
            t++;
            if (done_o) done_t.push_back(t);
        end
        chk("per_ndone", 32'(done_t.size()), 3);
        if (done_t.size() == 3) begin
            // Period is one reload cycle plus four RUN cycles.
            chk("per_gap1", 32'(done_t[1] - done_t[0]), 5);
            chk("per_gap2", 32'(done_t[2] - done_t[1]), 5);
        end
        chk("per_still_busy", 32'(busy_o), 1);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        step();
        chk("per_stopped", 32'(busy_o), 0);

        // Mid-run stop.
        step();
        arm(1'b0, 8'h10, 8'h20, 4'd0);
        step(); step();
        chk("stop_cnt_before", 32'(cnt_q), 32'h11);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("stop_clr",  32'(cnt_clr_o), 1);
        chk("stop_busy", 32'(busy_o), 1);
        step();
        chk("stop_idle", 32'(busy_o), 0);
        chk("stop_cnt0", 32'(cnt_q), 0);
        chk("stop_done", 32'(done_o), 0);
        chk("stop_clr_off", 32'(cnt_clr_o), 0);

        // stop + start together in IDLE.
        start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        chk("ss_busy", 32'(busy_o), 0);
        chk("ss_we",   32'(cnt_we_o), 0);
        chk("ss_clr",  32'(cnt_clr_o), 0);

`ifdef TIMER_CTRL_CAPTURE_EN
        arm(1'b0, 8'h0E, 8'h12, 4'd0);
        step(); step(); step();
        chk("cap_cnt", 32'(cnt_q), 32'h10);
        capture_i = 1'b1;
        step();
        capture_i = 1'b0;
        chk("cap_val", 32'(cap_o), 32'h10);
        for (int k = 0; k < 6; k++) step();
        chk("cap_idle", 32'(busy_o), 0);
        chk("cap_hold", 32'(cap_o), 32'h10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
